multi_channel_trigger: RTL and testbench

MULTI_CHANNEL_TRIGGER -- requirements
Module: multi_channel_trigger

---
 rtl/trig_pkg.sv | 18 +
 rtl/trig_channel.sv | 56 +++++
 rtl/multi_channel_trigger.sv | 104 ++++++++++
 tb/tb_multi_channel_trigger.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared definitions for the multi-channel trigger: config bit layout and FSM states.
package trig_pkg;

  localparam int unsigned CFG_W     = 5;
  localparam int unsigned CFG_FORCE = 0;
  localparam int unsigned CFG_LOW   = 1;
  localparam int unsigned CFG_HIGH  = 2;
  localparam int unsigned CFG_NEG   = 3;
  localparam int unsigned CFG_POS   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StHoldoff,
    StArmed,
    StTriggered
  } state_e;

endpackage

// File: rtl/trig_channel.sv
// One scope channel: registered comparator levels, sticky edge flags and the qualified
// trigger term selected by the channel's config bits.
module trig_channel
  import trig_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ch_hi_i,
  input  logic             ch_lo_i,
  input  logic [CFG_W-1:0] cfg_i,
  input  logic             armed_i,
  input  logic             clr_i,
  output logic             ch_trig_o
);

  logic hi_q, hi_d;
  logic lo_q, lo_d;
  logic pos_q, pos_d;
  logic neg_q, neg_d;

  always_comb begin
    hi_d  = ch_hi_i;
    lo_d  = ~ch_lo_i;
    pos_d = pos_q;
    neg_d = neg_q;
    // Clearing on an accepted arm/disarm takes priority over a same-cycle edge.
    if (clr_i) begin
      pos_d = 1'b0;
      neg_d = 1'b0;
    end else if (armed_i) begin
      if (ch_hi_i && !hi_q) pos_d = 1'b1;
      if (!ch_lo_i && !lo_q) neg_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= 1'b0;
      lo_q  <= 1'b0;
      pos_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      pos_q <= pos_d;
      neg_q <= neg_d;
    end
  end

  assign ch_trig_o = cfg_i[CFG_FORCE]
                   | (cfg_i[CFG_LOW]  & lo_q)
                   | (cfg_i[CFG_HIGH] & hi_q)
                   | (cfg_i[CFG_NEG]  & neg_q)
                   | (cfg_i[CFG_POS]  & pos_q);

endmodule

// File: rtl/multi_channel_trigger.sv
// Oscilloscope trigger: combines per-channel qualified terms (OR/AND of enabled channels)
// and runs the idle/holdoff/armed/triggered sequencer.
module multi_channel_trigger
  import trig_pkg::*;
#(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned HOLD_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_hi,
  input  logic [NUM_CH-1:0]       ch_lo,
  input  logic [NUM_CH*CFG_W-1:0] ch_cfg,
  input  logic                    combine_and,
  input  logic [HOLD_W-1:0]       holdoff,
  input  logic                    arm,
  input  logic                    disarm,
  output logic                    armed,
  output logic                    triggered,
  output logic                    trig_pulse,
  output logic [NUM_CH-1:0]       ch_trig
);

  localparam logic [HOLD_W-1:0] HoldOne = 1;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic [NUM_CH-1:0] ch_en;
  logic              fire;
  logic              in_armed;
  logic              clr;

  assign in_armed = (state_q == StArmed);
  assign clr      = arm | disarm;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trig_channel u_ch (
      .clk_i     (clk),
      .rst_i     (rst),
      .ch_hi_i   (ch_hi[i]),
      .ch_lo_i   (ch_lo[i]),
      .cfg_i     (ch_cfg[CFG_W*i +: CFG_W]),
      .armed_i   (in_armed),
      .clr_i     (clr),
      .ch_trig_o (ch_trig[i])
    );
    assign ch_en[i] = |ch_cfg[CFG_W*i +: CFG_W];
  end

  // Disabled channels are neutral in both modes; no enabled channel never fires.
  always_comb begin
    if (combine_and) fire = (|ch_en) && (&(ch_trig | ~ch_en));
    else             fire = |(ch_trig & ch_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (disarm) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (arm) begin
      if (holdoff == '0) begin
        state_d = StArmed;
        cnt_d   = '0;
      end else begin
        state_d = StHoldoff;
        cnt_d   = holdoff - HoldOne;
      end
    end else begin
      case (state_q)
        StHoldoff: begin
          if (cnt_q == '0) state_d = StArmed;
          else             cnt_d   = cnt_q - HoldOne;
        end
        StArmed: begin
          if (fire) state_d = StTriggered;
        end
        default: ;
      endcase
    end
    pulse_d = (state_q == StArmed) && (state_d == StTriggered);
  end

  always_comb begin
    armed      = (state_q == StArmed);
    triggered  = (state_q == StTriggered);
    trig_pulse = pulse_q;
  end

endmodule

// File: tb/tb_multi_channel_trigger.sv
// Scoreboard bench for multi_channel_trigger: stimulus queues expected trig_pulse cycles,
// a monitor pops and compares on every observed pulse.
module tb_multi_channel_trigger;

  localparam int NUM_CH = 5;
  localparam int HOLD_W = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_CH-1:0]     ch_hi;
  logic [NUM_CH-1:0]     ch_lo;
  logic [NUM_CH*5-1:0]   ch_cfg;
  logic                  combine_and;
  logic [HOLD_W-1:0]     holdoff;
  logic                  arm;
  logic                  disarm;
  logic                  armed;
  logic                  triggered;
  logic                  trig_pulse;
  logic [NUM_CH-1:0]     ch_trig;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];

  multi_channel_trigger #(
    .NUM_CH(NUM_CH),
    .HOLD_W(HOLD_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_hi       (ch_hi),
    .ch_lo       (ch_lo),
    .ch_cfg      (ch_cfg),
    .combine_and (combine_and),
    .holdoff     (holdoff),
    .arm         (arm),
    .disarm      (disarm),
    .armed       (armed),
    .triggered   (triggered),
    .trig_pulse  (trig_pulse),
    .ch_trig     (ch_trig)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (trig_pulse !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: pulse=%b at cycle %0d, expected none", trig_pulse, cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_disarm();
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
  endtask

  task automatic set_cfg(int ch, logic [4:0] v);
    ch_cfg[ch*5 +: 5] = v;
  endtask

  initial begin
    ch_hi       = '1;
    ch_lo       = '0;
    ch_cfg      = '0;
    combine_and = 1'b0;
    holdoff     = '0;
    arm         = 1'b0;
    disarm      = 1'b0;
    set_cfg(0, 5'b11110);
    set_cfg(3, 5'b00001);

    // Reset: registers held clear, so only the force bit shows through.
    tick(3);
    check("rst_armed", 32'(armed), 0);
    check("rst_triggered", 32'(triggered), 0);
    check("rst_pulse", 32'(trig_pulse), 0);
    check("rst_ch_trig", 32'(ch_trig), 32'h08);
    ch_hi  = '0;
    ch_lo  = '1;
    ch_cfg = '0;
    rst    = 1'b0;
    tick(2);
    check("idle_armed", 32'(armed), 0);

    // Positive edge on ch0, no holdoff.
    set_cfg(0, 5'b10000);
    do_arm();
    tick();
    check("t1_armed", 32'(armed), 1);
    ch_hi[0] = 1'b1;
    exp_q.push_back(cyc + 2);
    tick(3);
    check("t1_triggered", 32'(triggered), 1);
    check("t1_not_armed", 32'(armed), 0);
    tick(2);
    check("t1_hold", 32'(triggered), 1);
    check("t1_sb_empty", 32'(exp_q.size()), 0);
    // Re-arm from TRIGGERED must drop the sticky flag.
    ch_hi[0] = 1'b0;
    do_arm();
    check("t1_rearm", 32'(armed), 1);
    tick(3);
    check("t1_rearm_quiet", 32'(triggered), 0);
    do_disarm();
    check("t1_disarm", 32'(armed), 0);

    // Holdoff of 10: edge inside holdoff ignored, later edge triggers.
    holdoff = 16'd10;
    do_arm();
    tick(3);
    ch_hi[0] = 1'b1;
    tick(2);
    check("t2_holdoff_armed", 32'(armed), 0);
    check("t2_holdoff_trig", 32'(triggered), 0);
    ch_hi[0] = 1'b0;
    tick(4);
    check("t2_last_holdoff", 32'(armed), 0);
    tick();
    check("t2_enter_armed", 32'(armed), 1);
    ch_hi[0] = 1'b1;
    exp_q.push_back(cyc + 2);
    tick(3);
    check("t2_triggered", 32'(triggered), 1);
    do_disarm();
    ch_hi   = '0;
    holdoff = '0;
    tick();

    // AND mode: ch0 high level plus ch2 low level.
    ch_cfg      = '0;
    combine_and = 1'b1;
    set_cfg(0, 5'b00100);
    set_cfg(2, 5'b00010);
    do_arm();
    ch_hi[0] = 1'b1;
    tick(4);
    check("t3_partial_armed", 32'(armed), 1);
    check("t3_partial_ch_trig", 32'(ch_trig), 32'h01);
    ch_lo[2] = 1'b0;
    exp_q.push_back(cyc + 2);
    tick(3);
    check("t3_triggered", 32'(triggered), 1);
    check("t3_ch_trig", 32'(ch_trig), 32'h05);
    do_disarm();
    ch_hi       = '0;
    ch_lo       = '1;
    combine_and = 1'b0;
    tick(2);

    // No channel enabled: activity in both modes must never fire.
    ch_cfg = '0;
    do_arm();
    for (int i = 0; i < 100; i++) begin
      ch_hi       = NUM_CH'($urandom);
      ch_lo       = NUM_CH'($urandom);
      combine_and = (i >= 50);
      tick();
    end
    check("t4_still_armed", 32'(armed), 1);
    check("t4_ch_trig", 32'(ch_trig), 0);
    ch_hi       = '0;
    ch_lo       = '1;
    combine_and = 1'b0;
    do_disarm();
    set_cfg(1, 5'b00001);
    tick();
    check("t4_idle_no_fire", 32'(triggered), 0);
    exp_q.push_back(cyc + 2);
    do_arm();
    tick(2);
    check("t4_force_trig", 32'(triggered), 1);
    do_disarm();
    ch_cfg = '0;
    tick();

    // arm+disarm together while ARMED: disarm wins and flags clear.
    combine_and = 1'b1;
    set_cfg(0, 5'b10000);
    set_cfg(1, 5'b10000);
    do_arm();
    ch_hi[0] = 1'b1;
    tick(2);
    check("t5_flag_set", 32'(ch_trig), 32'h01);
    check("t5_armed", 32'(armed), 1);
    arm    = 1'b1;
    disarm = 1'b1;
    tick();
    arm    = 1'b0;
    disarm = 1'b0;
    check("t5_both_armed", 32'(armed), 0);
    check("t5_both_trig", 32'(triggered), 0);
    check("t5_flag_clr", 32'(ch_trig), 0);
    ch_hi       = '0;
    combine_and = 1'b0;
    tick();

    // Reset during holdoff aborts; a level that would fire later must not.
    ch_cfg = '0;
    set_cfg(0, 5'b00100);
    ch_hi[0] = 1'b1;
    holdoff  = 16'd5;
    do_arm();
    tick(2);
    check("t6_in_holdoff", 32'(armed), 0);
    rst = 1'b1;
    tick();
    check("t6_rst_armed", 32'(armed), 0);
    check("t6_rst_trig", 32'(triggered), 0);
    check("t6_rst_pulse", 32'(trig_pulse), 0);
    check("t6_rst_ch_trig", 32'(ch_trig), 0);
    rst = 1'b0;
    tick(10);
    check("t6_after_armed", 32'(armed), 0);
    check("t6_after_trig", 32'(triggered), 0);

    tick(2);
    check("final_sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
